// File: rtl/imm_extend_stage_if.sv
// rtl/imm_extend_stage_if.sv - handshake bundle between the decode stage, the immediate extender and execute
// Producer side: in_valid, in_ready, instr, mode, shift2, flush
// Consumer side: out_valid, out_ready, imm_out, illegal
// master: the block that drives instructions and consumes results
// slave:  the immediate extender itself
interface imm_extend_stage_if #(
    parameter int INSTR_W  = 32,
    parameter int WIDTHOUT = 64
);
    logic                in_valid;
    logic                in_ready;
    logic [INSTR_W-1:0]  instr;
    logic [2:0]          mode;
    logic                shift2;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTHOUT-1:0] imm_out;
    logic                illegal;

    modport master (
        output in_valid, instr, mode, shift2, flush, out_ready,
        input  in_ready, out_valid, imm_out, illegal
    );

    modport slave (
        input  in_valid, instr, mode, shift2, flush, out_ready,
        output in_ready, out_valid, imm_out, illegal
    );
endinterface

// File: rtl/imm_extend_stage.sv
// rtl/imm_extend_stage.sv - registered immediate extractor/extender at the decode->execute boundary
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      imm_extend_stage_if.slave
//            in_valid/in_ready/instr/mode/shift2/flush in, out_valid/out_ready/imm_out/illegal out
// mode: 0 ZERO12, 1 SIGN9, 2 SIGN26, 3 SIGN19, 4 MOVZ16, 5-7 illegal
module imm_extend_stage #(
    parameter int INSTR_W  = 32,
    parameter int WIDTHOUT = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    imm_extend_stage_if.slave bus
);
    localparam logic [2:0] M_ZERO12 = 3'd0;
    localparam logic [2:0] M_SIGN9  = 3'd1;
    localparam logic [2:0] M_SIGN26 = 3'd2;
    localparam logic [2:0] M_SIGN19 = 3'd3;
    localparam logic [2:0] M_MOVZ16 = 3'd4;
    // Highest half-word slot whose 16 bits still fit inside the output.
    localparam int MAX_HW = WIDTHOUT / 16 - 1;

    logic [WIDTHOUT-1:0] ext;
    logic [WIDTHOUT-1:0] next_imm;
    logic                next_illegal;
    logic [63:0]         movz_wide;
    logic [1:0]          hw;
    logic                accept;

    logic                valid_q;
    logic [WIDTHOUT-1:0] imm_q;
    logic                illegal_q;

    // Instruction bits outside every immediate field are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{bus.instr[INSTR_W-1:26], bus.instr[4:0]};

    assign hw           = bus.instr[22:21];
    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        ext          = '0;
        next_illegal = 1'b0;
        // MOVZ is built at full 64 bits, then truncated; out-of-range slots are flagged below.
        movz_wide    = {48'b0, bus.instr[20:5]} << {hw, 4'b0000};
        case (bus.mode)
            M_ZERO12: ext = {{(WIDTHOUT-12){1'b0}}, bus.instr[21:10]};
            M_SIGN9:  ext = {{(WIDTHOUT-9){bus.instr[20]}}, bus.instr[20:12]};
            M_SIGN26: ext = {{(WIDTHOUT-26){bus.instr[25]}}, bus.instr[25:0]};
            M_SIGN19: ext = {{(WIDTHOUT-19){bus.instr[23]}}, bus.instr[23:5]};
            M_MOVZ16: begin
                ext          = movz_wide[WIDTHOUT-1:0];
                next_illegal = bus.shift2 || (int'(hw) > MAX_HW);
            end
            default:  next_illegal = 1'b1;
        endcase
        // Shift after extension so the sign bits are already in place.
        if (bus.shift2) begin
            ext = ext << 2;
        end
        next_imm = next_illegal ? '0 : ext;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q   <= 1'b0;
            imm_q     <= '0;
            illegal_q <= 1'b0;
        end else if (bus.flush) begin
            // Drops both the held entry and anything accepted this cycle.
            valid_q   <= 1'b0;
            imm_q     <= '0;
            illegal_q <= 1'b0;
        end else if (accept) begin
            // Covers same-cycle drain and refill: the new entry overwrites with no bubble.
            valid_q   <= 1'b1;
            imm_q     <= next_imm;
            illegal_q <= next_illegal;
        end else if (valid_q && bus.out_ready) begin
            valid_q   <= 1'b0;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.imm_out   = imm_q;
    assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_imm_extend_stage.sv
// tb/tb_imm_extend_stage.sv - scoreboard bench for imm_extend_stage at WIDTHOUT 64 and 32
module tb_imm_extend_stage;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    imm_extend_stage_if #(.INSTR_W(32), .WIDTHOUT(64)) b64 ();
    imm_extend_stage_if #(.INSTR_W(32), .WIDTHOUT(32)) b32 ();

    assign b32.in_valid  = b64.in_valid;
    assign b32.instr     = b64.instr;
    assign b32.mode      = b64.mode;
    assign b32.shift2    = b64.shift2;
    assign b32.flush     = b64.flush;
    assign b32.out_ready = b64.out_ready;

    imm_extend_stage #(.INSTR_W(32), .WIDTHOUT(64)) dut64 (.clk(clk), .reset_n(reset_n), .bus(b64));
    imm_extend_stage #(.INSTR_W(32), .WIDTHOUT(32)) dut32 (.clk(clk), .reset_n(reset_n), .bus(b32));

    typedef struct packed {
        logic [63:0] v64;
        logic        il64;
        logic [63:0] v32;
        logic        il32;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    function automatic void model(input logic [31:0] ins, input logic [2:0] m, input logic s2,
                                  input int w, output logic [63:0] v, output logic il);
        int h;
        v  = 64'd0;
        il = 1'b0;
        h  = int'(ins[22:21]);
        case (m)
            3'd0: v = {52'd0, ins[21:10]};
            3'd1: v = {{55{ins[20]}}, ins[20:12]};
            3'd2: v = {{38{ins[25]}}, ins[25:0]};
            3'd3: v = {{45{ins[23]}}, ins[23:5]};
            3'd4: begin
                v  = {48'd0, ins[20:5]} << (16 * h);
                il = s2 || (16 * h + 16 > w);
            end
            default: il = 1'b1;
        endcase
        if (s2) v = v << 2;
        if (w < 64) v = v & ((64'd1 << w) - 64'd1);
        if (il) v = 64'd0;
    endfunction

    // Called one time unit before the rising edge: compare, then update the scoreboard.
    task automatic sample();
        exp_t e;
        logic hv;
        logic rdy;
        hv  = (q.size() != 0);
        rdy = !hv || b64.out_ready;
        check("out_valid64", b64.out_valid, hv);
        check("out_valid32", b32.out_valid, hv);
        check("in_ready", b64.in_ready, rdy);
        if (hv && b64.out_valid && b32.out_valid) begin
            check("imm64", b64.imm_out, q[0].v64);
            check("ill64", b64.illegal, q[0].il64);
            check("imm32", b32.imm_out, q[0].v32);
            check("ill32", b32.illegal, q[0].il32);
        end
        if (b64.flush) begin
            q.delete();
        end else begin
            if (hv && b64.out_ready) void'(q.pop_front());
            if (b64.in_valid && rdy) begin
                model(b64.instr, b64.mode, b64.shift2, 64, e.v64, e.il64);
                model(b64.instr, b64.mode, b64.shift2, 32, e.v32, e.il32);
                q.push_back(e);
            end
        end
    endtask

    task automatic cycle(input int dly);
        #(dly);
        sample();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input logic [31:0] ins, input logic [2:0] m, input logic s2);
        b64.instr  = ins;
        b64.mode   = m;
        b64.shift2 = s2;
    endtask

    // One accept into an empty stage, then leave the result held for direct checks.
    task automatic load(input logic [31:0] ins, input logic [2:0] m, input logic s2);
        set_in(ins, m, s2);
        b64.in_valid  = 1'b1;
        b64.out_ready = 1'b0;
        cycle(4);
        b64.in_valid  = 1'b0;
    endtask

    task automatic drain();
        b64.out_ready = 1'b1;
        cycle(4);
        b64.out_ready = 1'b0;
    endtask

    logic [63:0] held;

    initial begin
        reset_n       = 1'b0;
        b64.in_valid  = 1'b0;
        b64.flush     = 1'b0;
        b64.out_ready = 1'b0;
        set_in(32'd0, 3'd0, 1'b0);
        #2;
        check("rst_ov", b64.out_valid, 1'b0);
        check("rst_imm", b64.imm_out, 64'd0);
        check("rst_ill", b64.illegal, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", b64.in_ready, 1'b1);

        load(32'h001F_F000, 3'd1, 1'b0);
        check("t1_sign9", b64.imm_out, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t1_ill", b64.illegal, 1'b0);
        drain();

        load(32'h03FF_FFFF, 3'd2, 1'b1);
        check("t2_sign26_sh", b64.imm_out, 64'hFFFF_FFFF_FFFF_FFFC);
        drain();
        load(32'hFFFF_FFFF, 3'd0, 1'b0);
        check("t2_zero12", b64.imm_out, 64'h0000_0000_0000_0FFF);
        drain();

        load((32'd2 << 21) | (32'hABCD << 5), 3'd4, 1'b0);
        check("t3_movz64", b64.imm_out, 64'h0000_ABCD_0000_0000);
        check("t3_ill64", b64.illegal, 1'b0);
        check("t3_ill32", b32.illegal, 1'b1);
        check("t3_imm32", b32.imm_out, 64'd0);
        drain();

        b64.in_valid  = 1'b1;
        b64.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_in($urandom, 3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            cycle(4);
        end
        b64.out_ready = 1'b0;
        held = b64.imm_out;
        for (int i = 0; i < 3; i++) begin
            set_in($urandom, 3'd0, 1'b0);
            cycle(4);
            check("t4_in_ready", b64.in_ready, 1'b0);
            check("t4_hold", b64.imm_out, held);
        end

        b64.flush = 1'b1;
        cycle(4);
        b64.flush    = 1'b0;
        b64.in_valid = 1'b0;
        check("t5_flush_ov", b64.out_valid, 1'b0);
        check("t5_flush_imm", b64.imm_out, 64'd0);

        load(32'h0000_0400, 3'd0, 1'b0);
        check("t6_pre_ov", b64.out_valid, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        check("t6_async_ov", b64.out_valid, 1'b0);
        check("t6_async_ov32", b32.out_valid, 1'b0);
        check("t6_async_imm", b64.imm_out, 64'd0);
        q.delete();
        set_in(32'hFFFF_FFFF, 3'd6, 1'b0);
        b64.in_valid = 1'b1;
        #1 reset_n = 1'b1;
        cycle(1);
        b64.in_valid = 1'b0;
        check("t6_ill", b64.illegal, 1'b1);
        check("t6_imm", b64.imm_out, 64'd0);
        drain();

        for (int i = 0; i < 60; i++) begin
            b64.in_valid  = 1'($urandom_range(0, 1));
            b64.out_ready = 1'($urandom_range(0, 1));
            b64.flush     = ($urandom_range(0, 9) == 0);
            set_in($urandom, 3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
            cycle(4);
        end
        b64.in_valid = 1'b0;
        b64.flush    = 1'b0;
        b64.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle(4);
        check("final_empty", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
